stepper_multi_mover: RTL and testbench
======================================

Name: stepper_multi_mover

Overview:
- Parametrised successor to the single-move stepper driver that sits under the top-level board module.
- Drives NUM_CH step/dir stepper channels through one coordinated move; each channel gets its own signed step count.
- Step rate is set at runtime, direction setup time before the first step is enforced, and the move can be aborted.
- Keeps a signed position count per channel. Runs on the 25 MHz system clock; outputs drive the JB-header step/dir pins.

Parameters:
- NUM_CH, 6: number of stepper channels.
- STEP_W, 16: width of each signed per-channel step request.
- PERIOD_W, 16: width of the step-period input, in clock cycles.
- POS_W, 24: width of each signed position counter.
- DIR_SETUP, 25: clock cycles dir_pin is held stable before the first step edge.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- move_start  input  1  one-cycle start pulse.
- move_steps  input  NUM_CH*STEP_W  signed step counts, ch i at [i*STEP_W +: STEP_W].
- step_period  input  PERIOD_W  clock cycles per step.
- ch_enable  input  NUM_CH  channel mask; a masked channel moves 0 steps.
- abort  input  1  terminates the active move.
- move_busy  output  1  high from the cycle after an accepted start until done.
- move_done  output  1  one-cycle completion pulse.
- move_aborted  output  1  high with move_done if the move was aborted; holds until the next accepted start.
- dir_pin  output  NUM_CH  1 = negative direction.
- step_pin  output  NUM_CH  step pulses.
- position  output  NUM_CH*POS_W  signed position per channel.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, all positions 0.
- States: IDLE -> SETUP -> RUN -> DONE -> IDLE.

IDLE:
- move_start is accepted only in IDLE; it is ignored in every other state.
- On acceptance, per channel: latch dir = sign bit and remaining = |steps| (unsigned STEP_W bits, so -2^(STEP_W-1) gives magnitude 2^(STEP_W-1)). A masked channel gets remaining = 0 and keeps its dir_pin value.
- Latch period = max(step_period, 2).
- Next state SETUP; move_busy = 1 and dir_pin updated in the next cycle.

SETUP:
- Counts DIR_SETUP cycles, then goes to RUN. step_pin stays 0.

RUN:
- Each channel with remaining > 0 has its own phase counter.
- step_pin is high for HI = period>>1 cycles, then low for period-HI cycles.
- On each rising step edge: remaining decrements; position increments (dir = 0) or decrements (dir = 1), wrapping modulo 2^POS_W.
- The first step_pin high occurs in the first RUN cycle. A channel with N steps uses exactly N*period RUN cycles.
- A channel with N = 0 produces no pulses.
- RUN exits after the cycle in which every channel has remaining = 0 and has completed its low phase. If all channels are 0, RUN lasts one cycle.

DONE:
- move_done = 1 and move_busy = 0 for one cycle, then IDLE.

Abort:
- abort in SETUP or RUN: next cycle all step_pin = 0, state DONE, move_aborted = 1.
- Positions keep the steps already issued; a truncated high phase still counts as a step.
- abort in IDLE or DONE has no effect.
- abort together with move_start in IDLE: the start is accepted and the abort is ignored.

Other rules:
- step_period changes during a move have no effect.
- Asynchronous reset mid-move: step_pin drops immediately and positions clear.

Decomposition:
- Shared package stepper_pkg: state encoding (IDLE, SETUP, RUN, DONE), default DIR_SETUP, minimum period constant 2.
- One sub-module, stepper_channel, instantiated NUM_CH times in a generate loop. It holds remaining, phase counter, step_pin and position, and has inputs load, abort, run, period and outputs ch_idle, step, pos.
- The top holds the FSM, the SETUP counter and the all-idle AND reduction.

Test Plan:
- DIR_SETUP=4, period=4, ch0=+3, others 0, start at cycle 0 -> busy from cycle 1; step0 high cycles 5-6, 9-10, 13-14; move_done at cycle 17; position0 = 3; dir0 = 0.
- ch1=-2, ch2=+5, period=6 -> dir1 = 1 from cycle 1; ch1 gives 2 pulses of 3 cycles high; ch2 gives 5 pulses; done 1 cycle after ch2 finishes; positions -2 and +5.
- period=1, ch0=+2 -> clamped to 2; pulses 1 cycle high, 1 low; position0 = 2.
- ch0=+10, period=4, abort asserted in the RUN cycle of the 3rd rising step -> step_pin low next cycle, move_done + move_aborted pulse, position0 = 3.
- move_start held during busy, plus a second start pulse mid-RUN -> ignored: exactly one move_done, positions reflect one move. ch_enable=0 with ch0=+5 -> no pulses, done after SETUP plus one RUN cycle.
- reset low mid-RUN, POS_W=4 wrap: position 7 plus 1 step -> -8; reset -> all outputs 0 immediately.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the coordinated multi-channel stepper mover.
// State encoding and timing constants used by the top and its channels.
package stepper_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DONE
    } state_t;

    localparam int DIR_SETUP_DEF = 25;
    localparam int MIN_PERIOD    = 2;

endpackage

// File: rtl/stepper_multi_mover_channel.sv
// One step/dir channel: remaining-step count, phase counter, direction
// latch and signed position counter.
module stepper_channel #(
    parameter int STEP_W   = 16,
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                abort,
    input  logic                run,
    input  logic                en,
    input  logic [STEP_W-1:0]   steps,
    input  logic [PERIOD_W-1:0] period,
    output logic                ch_idle,
    output logic                step,
    output logic                dir,
    output logic [POS_W-1:0]    pos
);

    logic [STEP_W-1:0]   rem_q, rem_d, mag;
    logic [PERIOD_W-1:0] ph_q, ph_d, hi, last;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic                fire;

    assign hi   = period >> 1;
    assign last = period - PERIOD_W'(1);
    assign mag  = steps[STEP_W-1] ? (~steps + STEP_W'(1)) : steps;
    assign fire = run && (ph_q == '0) && (rem_q != '0);

    always_comb begin
        rem_d = rem_q;
        ph_d  = ph_q;
        pos_d = pos_q;
        dir_d = dir_q;
        // A step counts at its rising edge, even if abort truncates it.
        if (fire) begin
            pos_d = dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
        end
        if (load) begin
            rem_d = en ? mag : '0;
            dir_d = en ? steps[STEP_W-1] : dir_q;
            ph_d  = '0;
        end else if (abort) begin
            rem_d = '0;
            ph_d  = '0;
        end else if (run) begin
            if (fire) begin
                rem_d = rem_q - STEP_W'(1);
            end
            if (ph_q == last) begin
                ph_d = '0;
            end else if (ph_q != '0 || fire) begin
                ph_d = ph_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            ph_q  <= '0;
            pos_q <= '0;
            dir_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            ph_q  <= ph_d;
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    // Idle once no steps remain and the last low phase ends this cycle.
    assign ch_idle = (rem_q == '0) && (ph_q == '0 || ph_q == last);
    assign step    = run && ((ph_q == '0) ? (rem_q != '0) : (ph_q < hi));
    assign dir     = dir_q;
    assign pos     = pos_q;

endmodule

// File: rtl/stepper_multi_mover.sv
// Coordinated move controller: start/setup/run/done sequencing for
// NUM_CH step/dir channels with runtime period and abort.
module stepper_multi_mover
    import stepper_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int STEP_W    = 16,
    parameter int PERIOD_W  = 16,
    parameter int POS_W     = 24,
    parameter int DIR_SETUP = DIR_SETUP_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     move_start,
    input  logic [NUM_CH*STEP_W-1:0] move_steps,
    input  logic [PERIOD_W-1:0]      step_period,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     abort,
    output logic                     move_busy,
    output logic                     move_done,
    output logic                     move_aborted,
    output logic [NUM_CH-1:0]        dir_pin,
    output logic [NUM_CH-1:0]        step_pin,
    output logic [NUM_CH*POS_W-1:0]  position
);

    localparam int CNT_W = $clog2(DIR_SETUP + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);
    localparam logic [PERIOD_W-1:0] PMIN = PERIOD_W'(MIN_PERIOD);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                aborted_q, aborted_d;
    logic                accept, abort_act, run, all_idle;
    logic [NUM_CH-1:0]   idle;

    assign accept    = move_start && (state_q == S_IDLE);
    assign abort_act = abort && (state_q == S_SETUP || state_q == S_RUN);
    assign all_idle  = &idle;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (move_start) state_d = S_SETUP;
            S_SETUP: begin
                if (abort) state_d = S_DONE;
                else if (cnt_q == SETUP_LAST) state_d = S_RUN;
            end
            S_RUN:   if (abort || all_idle) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        move_busy = (state_q == S_SETUP) || (state_q == S_RUN);
        move_done = (state_q == S_DONE);
        run       = (state_q == S_RUN);
    end

    always_comb begin
        cnt_d     = (state_q == S_SETUP) ? cnt_q + CNT_W'(1) : '0;
        period_d  = period_q;
        aborted_d = aborted_q;
        if (accept) begin
            period_d  = (step_period < PMIN) ? PMIN : step_period;
            aborted_d = 1'b0;
        end else if (abort_act) begin
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            period_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            aborted_q <= aborted_d;
        end
    end

    assign move_aborted = aborted_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stepper_channel #(
            .STEP_W  (STEP_W),
            .PERIOD_W(PERIOD_W),
            .POS_W   (POS_W)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .load   (accept),
            .abort  (abort_act),
            .run    (run),
            .en     (ch_enable[i]),
            .steps  (move_steps[i*STEP_W +: STEP_W]),
            .period (period_q),
            .ch_idle(idle[i]),
            .step   (step_pin[i]),
            .dir    (dir_pin[i]),
            .pos    (position[i*POS_W +: POS_W])
        );
    end

endmodule

// File: tb/tb_stepper_multi_mover.sv
// Scoreboard bench for stepper_multi_mover: per-move expectations from a
// step-count/timing model, checked by a monitor at each move_done.
module tb_stepper_multi_mover;

    localparam int NC   = 3;
    localparam int SW   = 8;
    localparam int PW   = 8;
    localparam int POSW = 8;
    localparam int DS   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              move_start = 1'b0;
    logic [NC*SW-1:0]  move_steps = '0;
    logic [PW-1:0]     step_period = '0;
    logic [NC-1:0]     ch_enable = '0;
    logic              abort = 1'b0;
    logic              move_busy, move_done, move_aborted;
    logic [NC-1:0]     dir_pin, step_pin;
    logic [NC*POSW-1:0] position;

    stepper_multi_mover #(
        .NUM_CH(NC), .STEP_W(SW), .PERIOD_W(PW), .POS_W(POSW), .DIR_SETUP(DS)
    ) dut (
        .clock(clock), .reset(reset), .move_start(move_start),
        .move_steps(move_steps), .step_period(step_period),
        .ch_enable(ch_enable), .abort(abort), .move_busy(move_busy),
        .move_done(move_done), .move_aborted(move_aborted),
        .dir_pin(dir_pin), .step_pin(step_pin), .position(position)
    );

    always #20 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int              done_cyc;
        bit              aborted;
        int              busy;
        logic [NC*POSW-1:0] pos;
        logic [NC-1:0]   dir;
        logic [NC*16-1:0] pulses;
        logic [NC*16-1:0] highs;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int pc[NC], hc[NC];
    int busy_cnt = 0;
    logic [NC-1:0] prev_step = '0;
    logic [POSW-1:0] mpos[NC];
    bit mdir[NC];

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: accumulates pin activity and checks each completed move.
    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin pc[i] = 0; hc[i] = 0; end
            busy_cnt = 0;
            prev_step = '0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (step_pin[i] && !prev_step[i]) pc[i]++;
                if (step_pin[i]) hc[i]++;
            end
            prev_step = step_pin;
            if (move_busy) busy_cnt++;
            if (move_done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("aborted", int'(move_aborted), int'(e.aborted));
                    chk("busy_cycles", busy_cnt, e.busy);
                    chk("busy_in_done", int'(move_busy), 0);
                    for (int i = 0; i < NC; i++) begin
                        chk($sformatf("pos%0d", i),
                            int'(position[i*POSW +: POSW]), int'(e.pos[i*POSW +: POSW]));
                        chk($sformatf("dir%0d", i), int'(dir_pin[i]), int'(e.dir[i]));
                        chk($sformatf("pulses%0d", i), pc[i], int'(e.pulses[i*16 +: 16]));
                        chk($sformatf("highs%0d", i), hc[i], int'(e.highs[i*16 +: 16]));
                    end
                end
                for (int i = 0; i < NC; i++) begin pc[i] = 0; hc[i] = 0; end
                busy_cnt = 0;
            end
        end
    end

    task automatic check_reset_state();
        chk("rst_busy", int'(move_busy), 0);
        chk("rst_done", int'(move_done), 0);
        chk("rst_aborted", int'(move_aborted), 0);
        chk("rst_dir", int'(dir_pin), 0);
        chk("rst_step", int'(step_pin), 0);
        chk("rst_pos", int'(position), 0);
    endtask

    // abort_at: -1 for none, else offset from the first busy cycle.
    task automatic do_move(input logic [NC*SW-1:0] stv, input logic [NC-1:0] en,
                           input int per, input int abort_at, input bit noise,
                           input bit start_abort);
        int p, hi, maxn, runlen, total, k, t0, nd, s, iss, hcyc;
        int n[NC];
        bit abt;
        exp_t e;
        p = (per < 2) ? 2 : per;
        hi = p / 2;
        maxn = 0;
        for (int i = 0; i < NC; i++) begin
            s = int'($signed(stv[i*SW +: SW]));
            n[i] = en[i] ? ((s < 0) ? -s : s) : 0;
            if (n[i] > maxn) maxn = n[i];
        end
        runlen = (maxn * p > 1) ? maxn * p : 1;
        total = DS + runlen;
        t0 = cyc;
        abt = (abort_at >= 0) && (abort_at < total);
        if (abt) begin
            e.busy = abort_at + 1;
            e.done_cyc = t0 + abort_at + 2;
            k = abort_at - DS;
        end else begin
            e.busy = total;
            e.done_cyc = t0 + 1 + total;
            k = runlen - 1;
        end
        e.aborted = abt;
        for (int i = 0; i < NC; i++) begin
            s = int'($signed(stv[i*SW +: SW]));
            iss = (k < 0) ? 0 : ((k / p + 1 < n[i]) ? k / p + 1 : n[i]);
            hcyc = 0;
            if (iss > 0) begin
                hcyc = (iss - 1) * hi;
                hcyc += (k - (iss - 1) * p + 1 < hi) ? k - (iss - 1) * p + 1 : hi;
            end
            if (en[i]) mdir[i] = (s < 0);
            mpos[i] = mdir[i] ? mpos[i] - POSW'(iss) : mpos[i] + POSW'(iss);
            e.pos[i*POSW +: POSW] = mpos[i];
            e.dir[i] = mdir[i];
            e.pulses[i*16 +: 16] = 16'(iss);
            e.highs[i*16 +: 16] = 16'(hcyc);
        end
        q.push_back(e);
        nd = done_cnt;
        move_steps = stv;
        ch_enable = en;
        step_period = PW'(per);
        move_start = 1'b1;
        abort = start_abort;
        while (done_cnt == nd && cyc < t0 + 1200) begin
            @(posedge clock); #1;
            move_start = 1'b0;
            abort = abt && (cyc == t0 + 1 + abort_at);
            if (noise && cyc < e.done_cyc) begin
                move_start = ($urandom_range(0, 2) == 0);
                step_period = PW'($urandom);
            end
        end
        move_start = 1'b0;
        abort = 1'b0;
        chk("done_seen", done_cnt - nd, 1);
        @(posedge clock); #1;
    endtask

    function automatic logic [NC*SW-1:0] pack3(int a, int b, int c);
        logic [NC*SW-1:0] v;
        v[0*SW +: SW] = SW'(a);
        v[1*SW +: SW] = SW'(b);
        v[2*SW +: SW] = SW'(c);
        return v;
    endfunction

    initial begin
        int t0, per, ab;
        logic [NC*SW-1:0] stv;
        for (int i = 0; i < NC; i++) begin mpos[i] = '0; mdir[i] = 1'b0; end
        #5;
        check_reset_state();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check_reset_state();

        do_move(pack3(3, 0, 0), 3'b111, 4, -1, 1'b0, 1'b0);
        do_move(pack3(0, -2, 5), 3'b111, 6, -1, 1'b0, 1'b0);
        do_move(pack3(2, 0, 0), 3'b111, 1, -1, 1'b0, 1'b0);
        do_move(pack3(10, 0, 0), 3'b111, 4, DS + 8, 1'b0, 1'b0);
        do_move(pack3(4, -3, 2), 3'b111, 5, -1, 1'b1, 1'b0);
        do_move(pack3(5, 0, 0), 3'b110, 4, -1, 1'b0, 1'b0);
        do_move(pack3(0, 0, 0), 3'b111, 3, -1, 1'b0, 1'b1);
        do_move(pack3(-3, 2, 1), 3'b111, 3, 2, 1'b0, 1'b0);
        do_move(pack3(0, -128, 0), 3'b010, 2, -1, 1'b0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            stv = pack3($urandom_range(0, 12) - 6, $urandom_range(0, 12) - 6,
                        $urandom_range(0, 12) - 6);
            per = $urandom_range(0, 7);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DS + 6 * 7) : -1;
            if ($urandom_range(0, 2) == 0) begin
                abort = 1'b1;
                @(posedge clock); #1;
                abort = 1'b0;
            end
            do_move(stv, 3'($urandom), per, ab, 1'($urandom), 1'($urandom));
        end

        // Reset in the first RUN cycle, while channel 0 is mid-pulse.
        t0 = cyc;
        move_steps = pack3(5, -4, 0);
        ch_enable = 3'b111;
        step_period = 8'd4;
        move_start = 1'b1;
        @(posedge clock); #1;
        move_start = 1'b0;
        while (cyc < t0 + 1 + DS) begin
            @(posedge clock); #1;
        end
        chk("run_step_hi", int'(step_pin), 3);
        reset = 1'b0;
        #1;
        check_reset_state();
        for (int i = 0; i < NC; i++) begin mpos[i] = '0; mdir[i] = 1'b0; end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        do_move(pack3(127, 0, 0), 3'b001, 2, -1, 1'b0, 1'b0);
        do_move(pack3(1, 0, 0), 3'b001, 2, -1, 1'b0, 1'b0);
        chk("wrap_pos0", int'(position[0 +: POSW]), 128);

        chk("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
